// File: rtl/gate_tt_sequencer_pkg.sv
// Shared constants for the gate truth-table sequencer: FSM encodings,
// the reference NAND truth table and the per-vector compare helper.
package gate_tt_sequencer_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [3:0] NAND_TT = 4'b0111;

  // Truth-table bit index is {a,b}, which is exactly the vector number.
  function automatic logic vec_mismatch(input logic [3:0] tt, input logic [1:0] vec,
                                        input logic y);
    return (y != tt[vec]);
  endfunction

endpackage

// File: rtl/gate_tt_sequencer_if.sv
// Signal bundle between the sequencer (master) and the lab side that
// supplies start / the gate output and consumes the results (slave).
interface gate_tt_sequencer_if;
  logic       start;
  logic       gate_out;
  logic       drv_a;
  logic       drv_b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_cnt;
  logic [3:0] fail_vec;

  modport master (
    input  start, gate_out,
    output drv_a, drv_b, busy, done, pass, err_cnt, fail_vec
  );

  modport slave (
    output start, gate_out,
    input  drv_a, drv_b, busy, done, pass, err_cnt, fail_vec
  );
endinterface

// File: rtl/gate_tt_sequencer_timer.sv
// Settle timer: 8-bit counter cleared by load, advanced by en; last flags
// the final settle cycle for the current limit.
module tt_settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] limit,
  output logic       last
);
  logic [7:0] count_r;

  // Settle counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= 8'd0;
    end else if (load) begin
      count_r <= 8'd0;
    end else if (en) begin
      count_r <= count_r + 8'd1;
    end
  end

  assign last = (count_r == (limit - 8'd1));
endmodule

// File: rtl/nand_gate.sv
// Two-input NAND used as the reference gate under test.
module nand_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a & b);
endmodule

// File: rtl/gate_tt_sequencer.sv
// Steps a 2-input gate through all four input vectors, waits SETTLE_CYCLES
// per vector, samples the output and scores it against EXPECT.
module gate_tt_sequencer
  import gate_tt_sequencer_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [3:0]  EXPECT        = NAND_TT
) (
  input logic                 clk,
  input logic                 rst,
  gate_tt_sequencer_if.master bus
);
  localparam logic [7:0] SETTLE_LIM = 8'(SETTLE_CYCLES);

  logic [1:0] state_r;
  logic [1:0] vec_r;
  logic       drv_a_r;
  logic       drv_b_r;
  logic       busy_r;
  logic       done_r;
  logic       pass_r;
  logic [2:0] err_cnt_r;
  logic [3:0] fail_vec_r;

  logic       load_s;
  logic       en_s;
  logic       last_s;
  logic       mismatch_s;
  logic [2:0] err_next_s;

  tt_settle_timer u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (load_s),
    .en    (en_s),
    .limit (SETTLE_LIM),
    .last  (last_s)
  );

  assign mismatch_s = vec_mismatch(EXPECT, vec_r, bus.gate_out);
  assign err_next_s = err_cnt_r + {2'b00, mismatch_s};

  // Timer control: restart on run acceptance and after every check.
  always_comb begin
    load_s = 1'b0;
    en_s   = 1'b0;
    case (state_r)
      ST_IDLE:   load_s = bus.start;
      ST_SETTLE: en_s   = 1'b1;
      ST_CHECK:  load_s = 1'b1;
      default: begin
        load_s = 1'b0;
        en_s   = 1'b0;
      end
    endcase
  end

  // Sequencer FSM, vector drive and scoreboard registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      vec_r      <= 2'd0;
      drv_a_r    <= 1'b0;
      drv_b_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
      err_cnt_r  <= 3'd0;
      fail_vec_r <= 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            state_r    <= ST_SETTLE;
            vec_r      <= 2'd0;
            drv_a_r    <= 1'b0;
            drv_b_r    <= 1'b0;
            busy_r     <= 1'b1;
            pass_r     <= 1'b0;
            err_cnt_r  <= 3'd0;
            fail_vec_r <= 4'd0;
          end
        end
        ST_SETTLE: begin
          if (last_s) begin
            state_r <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          err_cnt_r <= err_next_s;
          if (mismatch_s) begin
            fail_vec_r[vec_r] <= 1'b1;
          end
          if (vec_r == 2'd3) begin
            // pass is taken from the post-check count so it is valid with done.
            state_r <= ST_DONE;
            drv_a_r <= 1'b0;
            drv_b_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            pass_r  <= (err_next_s == 3'd0);
          end else begin
            state_r            <= ST_SETTLE;
            vec_r              <= vec_r + 2'd1;
            {drv_a_r, drv_b_r} <= vec_r + 2'd1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.drv_a    = drv_a_r;
  assign bus.drv_b    = drv_b_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.pass     = pass_r;
  assign bus.err_cnt  = err_cnt_r;
  assign bus.fail_vec = fail_vec_r;
endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Scoreboard bench: stimulus pushes expected run results, per-DUT monitors
// pop and compare them whenever done is seen.
module tb_gate_tt_sequencer;
  import gate_tt_sequencer_pkg::*;

  typedef struct packed {
    logic [2:0]  err;
    logic [3:0]  fv;
    logic        pass;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cyc = 32'd0;
  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        m0_e;
  exp_t        m1_e;
  logic [1:0]  sel0;
  logic        nand0_y;
  logic        nand1_y;
  logic [31:0] n;

  gate_tt_sequencer_if bus0 ();
  gate_tt_sequencer_if bus1 ();

  nand_gate u_nand0 (.a(bus0.drv_a), .b(bus0.drv_b), .y(nand0_y));
  nand_gate u_nand1 (.a(bus1.drv_a), .b(bus1.drv_b), .y(nand1_y));

  // sel0: 0 real NAND, 1 stuck-at-1, 2 stuck-at-0
  assign bus0.gate_out = (sel0 == 2'd0) ? nand0_y : (sel0 == 2'd1);
  assign bus1.gate_out = nand1_y;

  gate_tt_sequencer #(.SETTLE_CYCLES(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  gate_tt_sequencer #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the S=4 instance.
  always @(negedge clk) begin
    if (bus0.done === 1'b1) begin
      if (q0.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL done0_unexpected: done=1 at cycle %0d, expected 0", cyc);
      end else begin
        m0_e = q0.pop_front();
        chk("done0_cycle", cyc, m0_e.cyc);
        chk("err_cnt0", {29'd0, bus0.err_cnt}, {29'd0, m0_e.err});
        chk("fail_vec0", {28'd0, bus0.fail_vec}, {28'd0, m0_e.fv});
        chk("pass0", {31'd0, bus0.pass}, {31'd0, m0_e.pass});
      end
    end
  end

  // Monitor for the S=1 instance.
  always @(negedge clk) begin
    if (bus1.done === 1'b1) begin
      if (q1.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL done1_unexpected: done=1 at cycle %0d, expected 0", cyc);
      end else begin
        m1_e = q1.pop_front();
        chk("done1_cycle", cyc, m1_e.cyc);
        chk("err_cnt1", {29'd0, bus1.err_cnt}, {29'd0, m1_e.err});
        chk("fail_vec1", {28'd0, bus1.fail_vec}, {28'd0, m1_e.fv});
        chk("pass1", {31'd0, bus1.pass}, {31'd0, m1_e.pass});
      end
    end
  end

  task automatic wait_cyc(input logic [31:0] target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int i = 0;
    while ((q0.size() != 0 || q1.size() != 0) && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: %0d results pending, expected 0", tag, q0.size() + q1.size());
      q0.delete();
      q1.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // One-cycle start pulse on dut0; done expected 21 cycles after the drive.
  task automatic run0(input logic [1:0] s, input logic [2:0] e, input logic [3:0] fv,
                      input logic p);
    sel0 = s;
    q0.push_back(exp_t'{err: e, fv: fv, pass: p, cyc: cyc + 32'd21});
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    sel0       = 2'd0;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset0_outputs", {19'd0, bus0.drv_a, bus0.drv_b, bus0.busy, bus0.done, bus0.pass,
                           bus0.err_cnt, bus0.fail_vec}, 32'd0);
    chk("reset1_outputs", {19'd0, bus1.drv_a, bus1.drv_b, bus1.busy, bus1.done, bus1.pass,
                           bus1.err_cnt, bus1.fail_vec}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // SETTLE_CYCLES=1: each vector held two cycles, done at cycle 8 after accept.
    n = cyc;
    q1.push_back(exp_t'{err: 3'd0, fv: 4'b0000, pass: 1'b1, cyc: n + 32'd9});
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("s1_drv", {30'd0, bus1.drv_a, bus1.drv_b}, 32'(i / 2));
      chk("s1_busy", {31'd0, bus1.busy}, 32'd1);
      @(negedge clk);
    end
    chk("s1_busy_end", {31'd0, bus1.busy}, 32'd0);
    drain("s1");

    run0(2'd0, 3'd0, 4'b0000, 1'b1);
    drain("good");
    run0(2'd1, 3'd1, 4'b1000, 1'b0);
    drain("stuck1");
    run0(2'd2, 3'd3, 4'b0111, 1'b0);
    drain("stuck0");

    // start pulses inside the run (and during DONE) must be ignored.
    n = cyc;
    run0(2'd0, 3'd0, 4'b0000, 1'b1);
    wait_cyc(n + 32'd5);  bus0.start = 1'b1; @(negedge clk); bus0.start = 1'b0;
    wait_cyc(n + 32'd19); bus0.start = 1'b1; @(negedge clk); bus0.start = 1'b0;
    wait_cyc(n + 32'd21); bus0.start = 1'b1; @(negedge clk); bus0.start = 1'b0;
    wait_cyc(n + 32'd23);
    chk("ignore_busy", {31'd0, bus0.busy}, 32'd0);
    drain("ignore");

    // start held high: back-to-back runs with one IDLE cycle between.
    n = cyc;
    sel0 = 2'd0;
    q0.push_back(exp_t'{err: 3'd0, fv: 4'b0000, pass: 1'b1, cyc: n + 32'd21});
    q0.push_back(exp_t'{err: 3'd0, fv: 4'b0000, pass: 1'b1, cyc: n + 32'd43});
    bus0.start = 1'b1;
    wait_cyc(n + 32'd22);
    chk("held_idle_busy", {31'd0, bus0.busy}, 32'd0);
    chk("held_idle_pass", {31'd0, bus0.pass}, 32'd1);
    @(negedge clk);
    chk("held_pass_clr", {31'd0, bus0.pass}, 32'd0);
    chk("held_busy2", {31'd0, bus0.busy}, 32'd1);
    bus0.start = 1'b0;
    drain("held");

    // rst during CHECK of vector 2 with a stuck-at-0 output.
    n = cyc;
    sel0 = 2'd2;
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    wait_cyc(n + 32'd15);
    chk("rst_pre_drv", {30'd0, bus0.drv_a, bus0.drv_b}, 32'd2);
    chk("rst_pre_err", {29'd0, bus0.err_cnt}, 32'd2);
    chk("rst_pre_fv", {28'd0, bus0.fail_vec}, 32'b0011);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_outputs", {19'd0, bus0.drv_a, bus0.drv_b, bus0.busy, bus0.done, bus0.pass,
                        bus0.err_cnt, bus0.fail_vec}, 32'd0);
    repeat (25) @(negedge clk);
    run0(2'd0, 3'd0, 4'b0000, 1'b1);
    drain("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
